// File: rtl/lsu_mem_responder_if.sv
// Request/response channel between the LSU and its memory responder.
interface lsu_mem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wen_i;
  logic        req_signed_i;
  logic [31:0] req_addr_i;
  logic [7:0]  req_mask_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  // LSU side: issues requests, consumes responses
  modport master (
    output req_valid_i, req_wen_i, req_signed_i, req_addr_i, req_mask_i, req_wdata_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  // Memory side: accepts requests, produces responses
  modport slave (
    input  req_valid_i, req_wen_i, req_signed_i, req_addr_i, req_mask_i, req_wdata_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/lsu_mem_responder.sv
// Latency-bearing word RAM responder for the LSU; one outstanding request at a time.
module lsu_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  lsu_mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam logic [32:0] ADDR_END = 33'(ADDR_BASE) + 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic        wen;
    logic        sgn;
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [31:0] wdata;
  } req_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  req_t             req_q;
  req_t             cur;
  logic             accept;
  logic             do_access;
  logic             in_range;
  logic             size_ok;
  logic             acc_err;
  logic             wr_en;
  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic [3:0]       be;
  logic [31:0]      wsh;
  logic [31:0]      rsh;
  logic [31:0]      ext_data;
  logic [31:0]      rsp_data;
  logic [31:0]      mem [DEPTH_WORDS];

  // Access decode; in IDLE the live inputs are used so a zero-latency build can respond at acceptance
  always_comb begin
    accept    = (state == IDLE) && bus.req_ready_o && bus.req_valid_i;
    cur       = req_q;
    if (state == IDLE) begin
      cur.wen   = bus.req_wen_i;
      cur.sgn   = bus.req_signed_i;
      cur.addr  = bus.req_addr_i;
      cur.mask  = bus.req_mask_i;
      cur.wdata = bus.req_wdata_i;
    end
    do_access = ((state == BUSY) && (cnt == '0)) || ((LATENCY == 0) && accept);
    off       = cur.addr[1:0];
    idx       = IDX_W'((cur.addr - ADDR_BASE) >> 2);
    in_range  = (cur.addr >= ADDR_BASE) && ({1'b0, cur.addr} < ADDR_END);
    case (cur.mask)
      8'h01:   size_ok = 1'b1;
      8'h03:   size_ok = !cur.addr[0];
      8'h0F:   size_ok = (off == 2'd0);
      default: size_ok = 1'b0;
    endcase
    acc_err  = !in_range || !size_ok;
    be       = 4'(cur.mask[3:0] << off);
    wsh      = cur.wdata << {off, 3'b000};
    rsh      = mem[idx] >> {off, 3'b000};
    case (cur.mask)
      8'h01:   ext_data = cur.sgn ? {{24{rsh[7]}}, rsh[7:0]} : {24'h0, rsh[7:0]};
      8'h03:   ext_data = cur.sgn ? {{16{rsh[15]}}, rsh[15:0]} : {16'h0, rsh[15:0]};
      default: ext_data = rsh;
    endcase
    rsp_data = (acc_err || cur.wen) ? '0 : ext_data;
    wr_en    = do_access && cur.wen && !acc_err && !rst_i;
  end

  // Byte-lane RAM write, committed only on the edge that enters RESP
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
      end
    end
  end

  // Request/response sequencing with registered handshake outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      cnt             <= '0;
      req_q           <= '0;
      bus.req_ready_o <= 1'b0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_rdata_o <= '0;
      bus.rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_q           <= cur;
            bus.req_ready_o <= 1'b0;
            if (LATENCY == 0) begin
              state           <= RESP;
              bus.rsp_valid_o <= 1'b1;
              bus.rsp_rdata_o <= rsp_data;
              bus.rsp_err_o   <= acc_err;
            end else begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end else begin
            bus.req_ready_o <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state           <= RESP;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_rdata_o <= rsp_data;
            bus.rsp_err_o   <= acc_err;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            state           <= IDLE;
            bus.rsp_valid_o <= 1'b0;
            bus.req_ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench for lsu_mem_responder: a LATENCY=2 instance and a LATENCY=0 instance.
module tb_lsu_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst0 = 1'b1;
  int   vectors = 0;
  int   errs = 0;

  lsu_mem_responder_if bus ();
  lsu_mem_responder_if bus0 ();

  lsu_mem_responder #(.ADDR_BASE(32'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  lsu_mem_responder #(.ADDR_BASE(32'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst0), .bus(bus0)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for ready, then present one request for exactly the acceptance edge
  task automatic issue(input logic wen, input logic sg, input logic [31:0] addr,
                       input logic [7:0] mask, input logic [31:0] wd, input string tag);
    for (int i = 0; i < 20 && !bus.req_ready_o; i++) tick();
    chk({tag, "_ready"}, 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i  = 1'b1;
    bus.req_wen_i    = wen;
    bus.req_signed_i = sg;
    bus.req_addr_i   = addr;
    bus.req_mask_i   = mask;
    bus.req_wdata_i  = wd;
    tick();
    bus.req_valid_i  = 1'b0;
    bus.req_wdata_i  = 32'h5555_AAAA;
  endtask

  // Count edges to response-valid and check the payload
  task automatic wait_rsp(input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int n = 0;
    while (!bus.rsp_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd2);
    chk({tag, "_rdata"}, bus.rsp_rdata_o, exp_rd);
    chk({tag, "_err"}, 32'(bus.rsp_err_o), 32'(exp_err));
  endtask

  task automatic finish_rsp(input string tag);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    chk({tag, "_vdrop"}, 32'(bus.rsp_valid_o), 32'd0);
    chk({tag, "_rdy"}, 32'(bus.req_ready_o), 32'd1);
  endtask

  task automatic xact(input logic wen, input logic sg, input logic [31:0] addr,
                      input logic [7:0] mask, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
    issue(wen, sg, addr, mask, wd, tag);
    wait_rsp(exp_rd, exp_err, tag);
    finish_rsp(tag);
  endtask

  initial begin
    int cnt0;
    bus.req_valid_i = 1'b0; bus.req_wen_i = 1'b0; bus.req_signed_i = 1'b0;
    bus.req_addr_i = '0; bus.req_mask_i = '0; bus.req_wdata_i = '0; bus.rsp_ready_i = 1'b0;
    bus0.req_valid_i = 1'b0; bus0.req_wen_i = 1'b0; bus0.req_signed_i = 1'b0;
    bus0.req_addr_i = '0; bus0.req_mask_i = '0; bus0.req_wdata_i = '0; bus0.rsp_ready_i = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_rdata", bus.rsp_rdata_o, 32'h0);
    chk("rst_err", 32'(bus.rsp_err_o), 32'd0);
    rst = 1'b0;
    rst0 = 1'b0;
    tick();
    chk("post_rst_ready", 32'(bus.req_ready_o), 32'd1);
    chk("post_rst_ready0", 32'(bus0.req_ready_o), 32'd1);
    chk("post_rst_valid0", 32'(bus0.rsp_valid_o), 32'd0);

    // Word store/load
    xact(1'b1, 1'b0, 32'h8000_0010, 8'h0F, 32'hDEAD_BEEF, 32'h0, 1'b0, "st_w");
    xact(1'b0, 1'b0, 32'h8000_0010, 8'h0F, 32'h0, 32'hDEAD_BEEF, 1'b0, "ld_w");

    // Byte store and sign/zero-extended loads
    xact(1'b1, 1'b0, 32'h8000_0012, 8'h01, 32'h0000_0080, 32'h0, 1'b0, "st_b");
    xact(1'b0, 1'b1, 32'h8000_0012, 8'h01, 32'h0, 32'hFFFF_FF80, 1'b0, "ld_bs");
    xact(1'b0, 1'b0, 32'h8000_0012, 8'h01, 32'h0, 32'h0000_0080, 1'b0, "ld_bu");
    xact(1'b0, 1'b0, 32'h8000_0010, 8'h0F, 32'h0, 32'hDE80_BEEF, 1'b0, "ld_w2");
    xact(1'b0, 1'b1, 32'h8000_0010, 8'h03, 32'h0, 32'hFFFF_BEEF, 1'b0, "ld_hs_lo");
    xact(1'b0, 1'b1, 32'h8000_0012, 8'h03, 32'h0, 32'hFFFF_DE80, 1'b0, "ld_hs_hi");
    xact(1'b0, 1'b0, 32'h8000_0012, 8'h03, 32'h0, 32'h0000_DE80, 1'b0, "ld_hu_hi");

    // Error cases; faulting stores must not write
    xact(1'b0, 1'b0, 32'h8000_0011, 8'h03, 32'h0, 32'h0, 1'b1, "err_half_mis");
    xact(1'b0, 1'b0, 32'h7FFF_FFFC, 8'h0F, 32'h0, 32'h0, 1'b1, "err_below");
    xact(1'b0, 1'b0, 32'h8000_1000, 8'h0F, 32'h0, 32'h0, 1'b1, "err_above");
    xact(1'b1, 1'b0, 32'h8000_0012, 8'h0F, 32'hFFFF_FFFF, 32'h0, 1'b1, "err_st_word_mis");
    xact(1'b1, 1'b0, 32'h8000_0010, 8'h07, 32'hFFFF_FFFF, 32'h0, 1'b1, "err_st_mask");
    xact(1'b0, 1'b0, 32'h8000_0010, 8'h0F, 32'h0, 32'hDE80_BEEF, 1'b0, "ld_w_unchanged");

    // Last valid word
    xact(1'b1, 1'b0, 32'h8000_0FFC, 8'h0F, 32'h0BAD_F00D, 32'h0, 1'b0, "st_last");
    xact(1'b0, 1'b0, 32'h8000_0FFC, 8'h0F, 32'h0, 32'h0BAD_F00D, 1'b0, "ld_last");

    // Back-pressure: response held stable, new requests ignored
    issue(1'b0, 1'b0, 32'h8000_0010, 8'h0F, 32'h0, "stall");
    wait_rsp(32'hDE80_BEEF, 1'b0, "stall");
    for (int i = 0; i < 5; i++) begin
      bus.req_valid_i = 1'b1;
      bus.req_wen_i   = 1'b1;
      bus.req_addr_i  = 32'h8000_0010;
      bus.req_mask_i  = 8'h0F;
      bus.req_wdata_i = 32'h0000_0000;
      tick();
      chk("stall_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("stall_rdata", bus.rsp_rdata_o, 32'hDE80_BEEF);
      chk("stall_ready", 32'(bus.req_ready_o), 32'd0);
    end
    bus.req_valid_i = 1'b0;
    finish_rsp("stall");
    xact(1'b0, 1'b0, 32'h8000_0010, 8'h0F, 32'h0, 32'hDE80_BEEF, 1'b0, "ld_after_stall");

    // Reset during BUSY drops the store
    xact(1'b1, 1'b0, 32'h8000_0020, 8'h0F, 32'hA5A5_0001, 32'h0, 1'b0, "st_pre");
    issue(1'b1, 1'b0, 32'h8000_0020, 8'h0F, 32'h1234_5678, "st_killed");
    rst = 1'b1;
    tick();
    tick();
    chk("kill_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("kill_ready", 32'(bus.req_ready_o), 32'd0);
    rst = 1'b0;
    tick();
    chk("kill_valid2", 32'(bus.rsp_valid_o), 32'd0);
    chk("kill_ready2", 32'(bus.req_ready_o), 32'd1);
    xact(1'b0, 1'b0, 32'h8000_0020, 8'h0F, 32'h0, 32'hA5A5_0001, 1'b0, "ld_pre");

    // Zero-latency instance: response right after acceptance, one request per two cycles
    bus0.req_valid_i = 1'b1;
    bus0.req_wen_i   = 1'b1;
    bus0.req_addr_i  = 32'h8000_0000;
    bus0.req_mask_i  = 8'h0F;
    bus0.req_wdata_i = 32'hCAFE_F00D;
    tick();
    chk("l0_st_valid", 32'(bus0.rsp_valid_o), 32'd1);
    chk("l0_st_rdata", bus0.rsp_rdata_o, 32'h0);
    chk("l0_st_ready", 32'(bus0.req_ready_o), 32'd0);
    bus0.req_wen_i = 1'b0;
    tick();
    chk("l0_hs_valid", 32'(bus0.rsp_valid_o), 32'd0);
    chk("l0_hs_ready", 32'(bus0.req_ready_o), 32'd1);
    tick();
    chk("l0_ld_valid", 32'(bus0.rsp_valid_o), 32'd1);
    chk("l0_ld_rdata", bus0.rsp_rdata_o, 32'hCAFE_F00D);
    chk("l0_ld_err", 32'(bus0.rsp_err_o), 32'd0);
    tick();
    cnt0 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus0.rsp_valid_o) cnt0++;
    end
    chk("l0_throughput", 32'(cnt0), 32'd4);
    bus0.req_valid_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
